// File: rtl/trg_exec_sequencer.sv
// Run-control sequencer for the minimum-trigger datapath: calibrates the ADC baseline,
// then arms the trigger block and counts trigger rising edges until stopped or at the limit.
module trg_exec_sequencer #(
    parameter int unsigned ADC_RESOLUTION_WIDTH = 12,
    parameter int unsigned S_AXIS_TDATA_WIDTH   = 128,
    parameter int unsigned CALIB_LOG2           = 4,
    parameter int unsigned TRG_COUNT_WIDTH      = 16
) (
    input  logic                            AXIS_ACLK,
    input  logic                            AXIS_ARESET,
    input  logic [S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic                            START,
    input  logic                            STOP,
    input  logic [TRG_COUNT_WIDTH-1:0]      TRG_LIMIT,
    input  logic                            TRIGGERD_FLAG,
    output logic [1:0]                      EXEC_STATE,
    output logic [ADC_RESOLUTION_WIDTH-1:0] BASELINE,
    output logic                            CALIB_DONE,
    output logic                            BUSY,
    output logic [TRG_COUNT_WIDTH-1:0]      TRG_COUNT
);

    localparam int unsigned Lanes    = S_AXIS_TDATA_WIDTH / 16;
    localparam int unsigned LaneLog2 = $clog2(Lanes);
    localparam int unsigned SumW     = ADC_RESOLUTION_WIDTH + LaneLog2;
    localparam int unsigned AccW     = SumW + CALIB_LOG2;
    localparam int unsigned Shift    = CALIB_LOG2 + LaneLog2;
    localparam int unsigned BeatW    = (CALIB_LOG2 > 0) ? CALIB_LOG2 : 1;
    localparam logic [BeatW-1:0] BeatLast = BeatW'((1 << CALIB_LOG2) - 1);

    typedef enum logic [1:0] {StIdle, StCalib, StCalc, StRun} state_e;

    state_e                            state_q, state_d;
    logic signed [AccW-1:0]            acc_q, acc_d;
    logic [BeatW-1:0]                  beat_q, beat_d;
    logic [TRG_COUNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic [ADC_RESOLUTION_WIDTH-1:0]   base_q, base_d;
    logic                              prev_q;
    logic [1:0]                        exec_q, exec_d;
    logic                              done_q, done_d;
    logic                              busy_q, busy_d;

    logic signed [SumW-1:0]                 lane_sum;
    logic signed [ADC_RESOLUTION_WIDTH-1:0] sample;
    logic signed [AccW-1:0]                 acc_shr;
    logic [TRG_COUNT_WIDTH-1:0]             cnt_inc;
    logic                                   rise;

    always_comb begin
        lane_sum = '0;
        sample   = '0;
        for (int i = 0; i < Lanes; i++) begin
            sample   = S_AXIS_TDATA[16*i+15 -: ADC_RESOLUTION_WIDTH];
            lane_sum = lane_sum + SumW'(sample);
        end
    end

    // Arithmetic shift floors toward negative infinity, matching the averaging intent.
    assign acc_shr = acc_q >>> Shift;
    assign rise    = TRIGGERD_FLAG & ~prev_q;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TRG_COUNT_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        if (STOP) begin
            state_d = StIdle;
        end else if (START) begin
            state_d = StCalib;
            acc_d   = '0;
            beat_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: state_d = StIdle;
                StCalib: begin
                    acc_d  = acc_q + AccW'(lane_sum);
                    beat_d = beat_q + BeatW'(1);
                    if (beat_q == BeatLast) begin
                        state_d = StCalc;
                    end
                end
                StCalc: begin
                    base_d  = acc_shr[ADC_RESOLUTION_WIDTH-1:0];
                    state_d = StRun;
                end
                StRun: begin
                    if (rise) begin
                        cnt_d = cnt_inc;
                        // Only equality on an increment stops; a lowered limit is ignored.
                        if ((TRG_LIMIT != '0) && (cnt_inc == TRG_LIMIT)) begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Status outputs are registered images of the current state.
    always_comb begin
        exec_d = (state_q == StRun) ? 2'b11 : 2'b00;
        done_d = (state_q == StRun);
        busy_d = (state_q != StIdle);
    end

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state_q <= StIdle;
            acc_q   <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            prev_q  <= 1'b0;
            exec_q  <= 2'b00;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            prev_q  <= TRIGGERD_FLAG;
            exec_q  <= exec_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign EXEC_STATE = exec_q;
    assign BASELINE   = base_q;
    assign CALIB_DONE = done_q;
    assign BUSY       = busy_q;
    assign TRG_COUNT  = cnt_q;

endmodule

// File: tb/tb_trg_exec_sequencer.sv
// Scoreboard bench for trg_exec_sequencer: stimulus queues expectations, a negedge
// monitor pops and compares them, and separately times every entry into RUN.
module tb_trg_exec_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] tdata;
    logic         start, stop, flag;
    logic [15:0]  limit;
    logic [1:0]   exec;
    logic [11:0]  base;
    logic         done, busy;
    logic [15:0]  cnt;

    always #5 clk = ~clk;

    trg_exec_sequencer dut (
        .AXIS_ACLK    (clk),
        .AXIS_ARESET  (rst),
        .S_AXIS_TDATA (tdata),
        .START        (start),
        .STOP         (stop),
        .TRG_LIMIT    (limit),
        .TRIGGERD_FLAG(flag),
        .EXEC_STATE   (exec),
        .BASELINE     (base),
        .CALIB_DONE   (done),
        .BUSY         (busy),
        .TRG_COUNT    (cnt)
    );

    typedef struct {
        string       name;
        logic [1:0]  exec;
        logic [11:0] base;
        logic        done;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        int unsigned cyc;
        logic [11:0] base;
    } lat_t;

    exp_t        exp_q[$];
    lat_t        lat_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    bit          fin_req = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : monitor
        exp_t       e;
        lat_t       l;
        logic [1:0] exec_prev;
        bit         fin_done;
        exec_prev = 2'b00;
        fin_done  = 1'b0;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (exec !== e.exec || base !== e.base || done !== e.done ||
                    busy !== e.busy || cnt !== e.cnt) begin
                    n_fail++;
                    $display("FAIL %s: got exec=%b base=%h done=%b busy=%b cnt=%0d, want exec=%b base=%h done=%b busy=%b cnt=%0d",
                             e.name, exec, base, done, busy, cnt,
                             e.exec, e.base, e.done, e.busy, e.cnt);
                end
            end
            if (exec == 2'b11 && exec_prev == 2'b00) begin
                n_vec++;
                if (lat_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL run_entry: RUN entered at cycle %0d, want no run", cyc);
                end else begin
                    l = lat_q.pop_front();
                    if (cyc != l.cyc || base !== l.base) begin
                        n_fail++;
                        $display("FAIL run_entry: got cycle %0d base=%h, want cycle %0d base=%h",
                                 cyc, base, l.cyc, l.base);
                    end
                end
            end
            exec_prev = exec;
            if (fin_req && !fin_done) begin
                n_vec++;
                if (lat_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL pending_runs: got %0d runs never entered, want 0", lat_q.size());
                end
                fin_done = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [11:0] a, input logic [11:0] b);
        for (int i = 0; i < 8; i++) begin
            tdata[16*i +: 16] = (i % 2 == 0) ? {a, 4'h0} : {b, 4'h0};
        end
    endtask

    task automatic expect_snap(input string nm, input logic [1:0] ex, input logic [11:0] b,
                               input logic d, input logic bz, input logic [15:0] c);
        exp_t e;
        e.name = nm;
        e.exec = ex;
        e.base = b;
        e.done = d;
        e.busy = bz;
        e.cnt  = c;
        exp_q.push_back(e);
    endtask

    // START sampled at edge 0; RUN with a valid baseline is due 18 edges later.
    task automatic pulse_start(input bit want_run, input logic [11:0] want_base);
        lat_t l;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        if (want_run) begin
            l.cyc  = cyc + 18;
            l.base = want_base;
            lat_q.push_back(l);
        end
    endtask

    task automatic flag_pulse();
        flag = 1'b1;
        tick(5);
        flag = 1'b0;
        tick(5);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        flag  = 1'b0;
        limit = 16'd0;
        tdata = '0;
        tick(3);
        expect_snap("reset", 2'b00, 12'h000, 1'b0, 1'b0, 16'd0);
        tick(1);
        rst = 1'b0;
        tick(2);

        set_lanes(12'd100, 12'd100);
        pulse_start(1'b1, 12'd100);
        tick(18);
        expect_snap("run_100", 2'b11, 12'd100, 1'b1, 1'b1, 16'd0);

        set_lanes(12'hFFB, 12'hFFB);
        pulse_start(1'b1, 12'hFFB);
        tick(18);
        expect_snap("base_neg5", 2'b11, 12'hFFB, 1'b1, 1'b1, 16'd0);

        set_lanes(12'hFFF, 12'h000);
        pulse_start(1'b1, 12'hFFF);
        tick(18);
        expect_snap("base_floor", 2'b11, 12'hFFF, 1'b1, 1'b1, 16'd0);

        set_lanes(12'd100, 12'd100);
        limit = 16'd3;
        pulse_start(1'b1, 12'd100);
        tick(18);
        flag_pulse();
        expect_snap("trg_1", 2'b11, 12'd100, 1'b1, 1'b1, 16'd1);
        flag_pulse();
        expect_snap("trg_2", 2'b11, 12'd100, 1'b1, 1'b1, 16'd2);
        flag = 1'b1;
        tick(2);
        expect_snap("limit_stop", 2'b00, 12'd100, 1'b0, 1'b0, 16'd3);
        tick(3);
        flag = 1'b0;
        tick(5);
        flag_pulse();
        expect_snap("after_limit", 2'b00, 12'd100, 1'b0, 1'b0, 16'd3);

        limit = 16'd0;
        pulse_start(1'b1, 12'd100);
        tick(18);
        flag = 1'b1;
        tick(50);
        expect_snap("unlimited_hold", 2'b11, 12'd100, 1'b1, 1'b1, 16'd1);
        flag = 1'b0;
        tick(2);

        set_lanes(12'd200, 12'd200);
        pulse_start(1'b0, 12'd0);
        tick(7);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(1);
        expect_snap("stop_calib", 2'b00, 12'd100, 1'b0, 1'b0, 16'd0);
        tick(20);
        expect_snap("stay_idle", 2'b00, 12'd100, 1'b0, 1'b0, 16'd0);
        stop  = 1'b1;
        start = 1'b1;
        tick(1);
        stop  = 1'b0;
        start = 1'b0;
        tick(2);
        expect_snap("stop_wins", 2'b00, 12'd100, 1'b0, 1'b0, 16'd0);

        pulse_start(1'b1, 12'd200);
        tick(18);
        flag = 1'b1;
        tick(2);
        flag = 1'b0;
        tick(2);
        expect_snap("run_200", 2'b11, 12'd200, 1'b1, 1'b1, 16'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        expect_snap("async_reset", 2'b00, 12'h000, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        tick(2);

        fin_req = 1'b1;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/trg_exec_sequencer.md
Name: trg_exec_sequencer

Overview:
Run-control sequencer for the minimum-trigger datapath. On a start request it calibrates the ADC baseline by averaging a power-of-two number of S_AXIS_TDATA beats, then drives EXEC_STATE and BASELINE into the trigger block. It arms the trigger, counts trigger rising edges, and returns the trigger to INIT on a stop request or when a programmed trigger limit is reached.

Parameters:
ADC_RESOLUTION_WIDTH, 12, ADC sample width; each sample is the upper bits of a 16-bit lane.
S_AXIS_TDATA_WIDTH, 128, RF data converter stream width; lanes = S_AXIS_TDATA_WIDTH/16 (8 by default).
CALIB_LOG2, 4, calibration length is 2^CALIB_LOG2 beats.
TRG_COUNT_WIDTH, 16, width of the trigger counter and the limit.

Ports:
AXIS_ACLK  in  1  the block's single clock.
AXIS_ARESET  in  1  asynchronous, active-high reset.
S_AXIS_TDATA  in  S_AXIS_TDATA_WIDTH  ADC stream; lane i sample = S_AXIS_TDATA[16*i+15 -: ADC_RESOLUTION_WIDTH], signed.
START  in  1  single-cycle pulse: begin calibrate-then-run.
STOP  in  1  single-cycle pulse: abort and return to idle.
TRG_LIMIT  in  TRG_COUNT_WIDTH  number of triggers after which the block auto-stops; 0 = unlimited.
TRIGGERD_FLAG  in  1  triggered flag from the trigger block.
EXEC_STATE  out  2  2'b00 = INIT, 2'b11 = TRG; other codes never driven.
BASELINE  out  ADC_RESOLUTION_WIDTH  signed calibrated baseline.
CALIB_DONE  out  1  high only in RUN.
BUSY  out  1  high in CALIB, CALC and RUN.
TRG_COUNT  out  TRG_COUNT_WIDTH  number of triggers in the current run.

Behaviour:
- Clock and reset: one clock, AXIS_ACLK. Reset is asynchronous and active-high, on AXIS_ARESET.
- Reset values: state = IDLE, EXEC_STATE = 00, BASELINE = 0, CALIB_DONE = 0, BUSY = 0, TRG_COUNT = 0, accumulator = 0, beat counter = 0, previous-flag register = 0.
- All outputs are registered.
- States and transitions:
  - IDLE: EXEC_STATE = 00. START goes to CALIB.
  - CALIB: EXEC_STATE = 00. Each cycle, add the lane sum of the current beat to the accumulator. The beat counter runs 0 to 2^CALIB_LOG2-1. The cycle with counter = max goes to CALC.
  - CALC: lasts one cycle. BASELINE <= acc >>> (CALIB_LOG2 + log2(lanes)), an arithmetic shift that rounds toward negative infinity, truncated to ADC_RESOLUTION_WIDTH. Next state is RUN.
  - RUN: EXEC_STATE = 11, CALIB_DONE = 1.
- Entering CALIB clears the accumulator, beat counter and TRG_COUNT. BASELINE holds its old value until CALC.
- Arithmetic widths:
  - Lane sum: signed, ADC_RESOLUTION_WIDTH + log2(lanes) bits.
  - Accumulator: signed, ADC_RESOLUTION_WIDTH + log2(lanes) + CALIB_LOG2 bits (19 by default), sign-extended adds, no overflow possible.
- Latency: with the START pulse sampled at edge 0, CALIB occupies edges 1..2^CALIB_LOG2 and CALC is the next cycle. EXEC_STATE becomes 11 and BASELINE is valid at edge 2^CALIB_LOG2 + 2 (edge 18 by default).
- Trigger counting: rising-edge detection is TRIGGERD_FLAG & ~prev. prev updates every cycle in every state.
  - In RUN, each rising edge increments TRG_COUNT, saturating at all-ones.
  - If TRG_LIMIT != 0 and the incremented value equals TRG_LIMIT, go to IDLE on that same edge. TRG_COUNT holds the final value.
  - Rising edges outside RUN are ignored.
- Priorities and boundary conditions:
  - STOP in any state goes to IDLE next cycle.
  - STOP and START in the same cycle: STOP wins.
  - START in CALIB or CALC restarts CALIB, clearing the accumulator.
  - START in RUN re-calibrates: goes to CALIB with EXEC_STATE = 00.
  - STOP during CALIB or CALC: BASELINE keeps its previous value.
  - TRG_LIMIT is sampled live. Lowering it below TRG_COUNT in RUN does not stop the run; only equality on an increment does.
  - Asserting AXIS_ARESET in any state forces all reset values immediately, with no clock required.

Test Plan:
- All lanes = 100; pulse START -> EXEC_STATE = 11, BASELINE = 100 and CALIB_DONE = 1 exactly 18 cycles after the START edge; EXEC_STATE = 00 on every earlier cycle.
- All lanes = -5 (0xFFB0 per lane) -> BASELINE = -5 (0xFFB); lanes alternating -1/0 -> sum -64 over 128 samples -> BASELINE = -1 (floor of -0.5).
- TRG_LIMIT = 3 in RUN; apply 3 TRIGGERD_FLAG pulses, each 5 cycles high and 5 low -> TRG_COUNT 1, 2, 3; IDLE and EXEC_STATE = 00 the cycle after the 3rd rising edge; a 4th pulse leaves TRG_COUNT = 3.
- TRG_LIMIT = 0 with the flag held high for 50 cycles -> TRG_COUNT = 1 and RUN persists.
- After a run with BASELINE = 100, START with lanes = 200, then STOP at CALIB beat 7 -> IDLE, BASELINE = 100; STOP and START in the same cycle -> IDLE.
- AXIS_ARESET asserted mid-RUN between clock edges -> EXEC_STATE = 00, BASELINE = 0, TRG_COUNT = 0, BUSY = 0 immediately, before the next edge.
